imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Pipelined, parametrised immediate-extension unit for the ARM-subset core decode path.
//  Takes the 24-bit instruction immediate field and ImmSrc, produces a DATA_W-bit extended
//  immediate plus shifter carry. Adds rotated-imm8 and an illegal-mode flag.
//  Adds valid/ready handshakes and a side-band tag so the unit can sit between the fetch/decode
//  and execute stages of the pipelined core. Stalls come from back-pressure.
// PARAMETERS
//  DATA_W   32  width of ExtImm; must be >= 32 (upper bits sign/zero-filled per mode)
//  STAGES   2   pipeline depth, 1 or 2; any other value is a elaboration error ($error)
//  TAG_W    5   width of side-band tag (e.g. destination reg) carried alongside the data
// PORTS
//  CLK        in   1        rising-edge clock
//  RESETn     in   1        asynchronous, active-low reset
//  InValid    in   1        input beat valid
//  InReady    out  1        unit can accept a beat this cycle
//  ImmSrc     in   2        00 rot-imm8, 01 imm12, 10 branch imm24, 11 illegal
//  InstrImm   in   24       instruction bits [23:0]
//  CarryIn    in   1        current C flag (for rot==0 carry passthrough)
//  InTag      in   TAG_W    side-band tag
//  OffsetUp   in   1        U bit for imm12 offsets (used only with EXTEND_NEG_OFFSET_EN)
//  OutValid   out  1        output beat valid
//  OutReady   in   1        downstream accepts beat
//  ExtImm     out  DATA_W   extended immediate
//  ImmCarry   out  1        shifter carry-out
//  ImmErr     out  1        beat carried ImmSrc==11
//  OutTag     out  TAG_W    tag of the beat on the output
// BEHAVIOUR
//  - Reset (RESETn low, async): all stage valids 0, OutValid 0, ExtImm 0, ImmCarry 0, ImmErr 0,
//    OutTag 0; InReady 1 from the first edge after release. Reset mid-operation discards
//    all in-flight beats; no beat emerges after reset.
//  - Transfer occurs when Valid&&Ready on the same rising edge. Per-stage rule:
//    stage_ready = !stage_valid || next_ready; no combinational path InValid->OutValid.
//    InReady = stage1 ready. This is combinational from OutReady through the stages, with
//    no skid buffer.
//  - Latency: STAGES cycles from accepted input to OutValid under no back-pressure.
//    Throughput: 1 beat/cycle. Order preserved; outputs held stable while OutValid && !OutReady.
//  - STAGES==2: stage1 registers the raw fields and mode; stage2 registers the computed result.
//    STAGES==1: compute combinationally and register once.
//  - Mode 00: imm8=InstrImm[7:0], rot=InstrImm[11:8]; ExtImm = zero-ext(imm8 ROR (2*rot))
//    within 32 bits, upper DATA_W-32 bits 0. ImmCarry = (rot==0) ? CarryIn : result[31].
//  - Mode 01: ExtImm = zero-ext(InstrImm[11:0]); ImmCarry = CarryIn.
//  - Mode 10: ExtImm = sign-ext({InstrImm[23:0],2'b00}) to DATA_W; ImmCarry = CarryIn.
//  - Mode 11: ExtImm = 0, ImmCarry = CarryIn, ImmErr = 1. The beat still flows and is not dropped.
//  - Simultaneous accept on input and drain on output in the same cycle: both happen, and the
//    pipeline stays full.
// CONFIGURATION
//  EXTEND_NEG_OFFSET_EN defined: in mode 01, when OffsetUp==0 ExtImm = -(zero-ext imm12)
//    (two's complement over DATA_W), so imm12=0 gives 0. OffsetUp is sampled with the beat.
//  Not defined: OffsetUp is ignored (unconnected internally); mode 01 is always positive.
// STRUCTURE
//  Package imm_ext_pkg: ImmSrc encodings (IMM_ROT8, IMM_U12, IMM_BR24, IMM_ILL) as a 2-bit enum;
//    ROT_W=4, IMM_FIELD_W=24.
//  Sub-module imm_ext_core: pure combinational compute (mode, field, carry -> result, carry,
//    err). It is instantiated once, and the pipeline wrapper owns all registers and handshakes.
// TESTING
//  1 Rot: ImmSrc=00, InstrImm=24'h000_4FF (rot=4, imm8=FF), CarryIn=0 ->
//    ExtImm=32'hFF00_0000, ImmCarry=1 after 2 cycles.
//  2 Branch: ImmSrc=10, InstrImm=24'hFFFFFE -> ExtImm=32'hFFFF_FFF8. Also InstrImm=24'h000001 ->
//    ExtImm=32'h0000_0004.
//  3 Back-pressure: stream 4 tagged beats (tags 1..4) with OutReady low for 3 cycles.
//    InReady must drop once both stages are full. Outputs must hold and all tags emerge in order
//    1..4 with no loss or duplication.
//  4 Illegal: ImmSrc=11, InTag=7 -> OutValid with ImmErr=1, ExtImm=0, OutTag=7. The next legal
//    beat has ImmErr=0.
//  5 Reset mid-flight: 2 beats in flight, pulse RESETn low asynchronously between edges ->
//    OutValid=0 immediately, and no stale beat after release.
//  6 EXTEND_NEG_OFFSET_EN: ImmSrc=01, InstrImm=24'h000_004, OffsetUp=0 -> ExtImm=32'hFFFF_FFFC.
//    Without the macro the same stimulus gives 32'h0000_0004.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: immediate-source encodings and field widths shared by the
// immediate-extension core and its pipeline wrapper.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_ROT8 = 2'b00,
        IMM_U12  = 2'b01,
        IMM_BR24 = 2'b10,
        IMM_ILL  = 2'b11
    } imm_src_e;

    localparam int ROT_W       = 4;
    localparam int IMM_FIELD_W = 24;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension (rotated imm8, imm12, branch imm24)
// with shifter carry-out and illegal-mode flag. Holds no state.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  imm_src_e                 mode,
    input  logic [IMM_FIELD_W-1:0]   field,
    input  logic                     carry_in,
    input  logic                     offset_up,
    output logic [DATA_W-1:0]        result,
    output logic                     carry_out,
    output logic                     err
);

    logic [ROT_W-1:0]               rot;
    logic [5:0]                     rot_amt;
    logic [31:0]                    rot_base;
    logic [31:0]                    rot_val;
    logic signed [IMM_FIELD_W+1:0]  br_off;

    assign rot      = field[11:8];
    assign rot_amt  = {1'b0, rot, 1'b0};
    assign rot_base = {24'h000000, field[7:0]};
    // A shift by 32 yields zero, so rot==0 needs no special case here
    assign rot_val  = (rot_base >> rot_amt) | (rot_base << (6'd32 - rot_amt));
    assign br_off   = {field, 2'b00};

    always_comb begin
        result    = '0;
        carry_out = carry_in;
        err       = 1'b0;
        case (mode)
            IMM_ROT8: begin
                result[31:0] = rot_val;
                if (rot != '0) begin
                    carry_out = rot_val[31];
                end
            end
            IMM_U12: begin
                result[11:0] = field[11:0];
                if (!offset_up) begin
                    result = -result;
                end
            end
            IMM_BR24: begin
                result = DATA_W'(br_off);
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: valid/ready pipelined immediate extender (1 or 2 stages) with a side-band tag.
// Optional macro EXTEND_NEG_OFFSET_EN: negate imm12 offsets when OffsetUp is low.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [1:0]             ImmSrc,
    input  logic [IMM_FIELD_W-1:0] InstrImm,
    input  logic                   CarryIn,
    input  logic [TAG_W-1:0]       InTag,
    input  logic                   OffsetUp,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [DATA_W-1:0]      ExtImm,
    output logic                   ImmCarry,
    output logic                   ImmErr,
    output logic [TAG_W-1:0]       OutTag
);

    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("imm_extend_pipe: STAGES must be 1 or 2");
    end
    if (DATA_W < 32) begin : g_bad_width
        $error("imm_extend_pipe: DATA_W must be >= 32");
    end

    imm_src_e               core_mode;
    logic [IMM_FIELD_W-1:0] core_field;
    logic                   core_carry_in;
    logic                   core_up;
    logic [DATA_W-1:0]      core_result;
    logic                   core_carry;
    logic                   core_err;
    logic                   up_valid;
    logic [TAG_W-1:0]       up_tag;
    logic                   out_ready;

`ifndef EXTEND_NEG_OFFSET_EN
    logic unused_offset_up;
    assign unused_offset_up = OffsetUp;
`endif

    assign out_ready = !OutValid || OutReady;

    if (STAGES == 2) begin : g_two
        logic                   s1_valid;
        imm_src_e               s1_mode;
        logic [IMM_FIELD_W-1:0] s1_field;
        logic                   s1_carry;
        logic [TAG_W-1:0]       s1_tag;

        assign InReady = !s1_valid || out_ready;

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                s1_valid <= 1'b0;
                s1_mode  <= IMM_ROT8;
                s1_field <= '0;
                s1_carry <= 1'b0;
                s1_tag   <= '0;
            end else if (InReady) begin
                s1_valid <= InValid;
                if (InValid) begin
                    s1_mode  <= imm_src_e'(ImmSrc);
                    s1_field <= InstrImm;
                    s1_carry <= CarryIn;
                    s1_tag   <= InTag;
                end
            end
        end

`ifdef EXTEND_NEG_OFFSET_EN
        logic s1_up;
        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                s1_up <= 1'b1;
            end else if (InReady && InValid) begin
                s1_up <= OffsetUp;
            end
        end
        assign core_up = s1_up;
`else
        assign core_up = 1'b1;
`endif

        assign up_valid      = s1_valid;
        assign up_tag        = s1_tag;
        assign core_mode     = s1_mode;
        assign core_field    = s1_field;
        assign core_carry_in = s1_carry;
    end else begin : g_one
        assign InReady       = out_ready;
        assign up_valid      = InValid;
        assign up_tag        = InTag;
        assign core_mode     = imm_src_e'(ImmSrc);
        assign core_field    = InstrImm;
        assign core_carry_in = CarryIn;
`ifdef EXTEND_NEG_OFFSET_EN
        assign core_up       = OffsetUp;
`else
        assign core_up       = 1'b1;
`endif
    end

    imm_ext_core #(.DATA_W(DATA_W)) u_core (
        .mode      (core_mode),
        .field     (core_field),
        .carry_in  (core_carry_in),
        .offset_up (core_up),
        .result    (core_result),
        .carry_out (core_carry),
        .err       (core_err)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            OutValid <= 1'b0;
            ExtImm   <= '0;
            ImmCarry <= 1'b0;
            ImmErr   <= 1'b0;
            OutTag   <= '0;
        end else if (out_ready) begin
            OutValid <= up_valid;
            if (up_valid) begin
                ExtImm   <= core_result;
                ImmCarry <= core_carry;
                ImmErr   <= core_err;
                OutTag   <= up_tag;
            end
        end
    end

endmodule
